// File: rtl/cpu_muldiv.sv
// Iterative 32-bit unsigned multiply/divide unit: 32 iterations, result written back in a one-cycle DONE state.
// Latency: start accepted at E0, write-back valid after E32. A start while busy is dropped, not queued.
module cpu_muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [3:0]  dst,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        wb_en,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_data,
    output logic        div0
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [1:0]  op_q;
    logic [3:0]  dst_q;
    logic        div0_q;
    logic [31:0] opd_q;      // multiplicand or divisor
    logic [32:0] hi_q;       // accumulator or partial remainder
    logic [31:0] lo_q;       // multiplier or dividend/quotient

    logic        accept;
    logic [32:0] mul_sum;
    logic [32:0] div_sh;
    logic [33:0] div_diff;
    logic [32:0] hi_nxt;
    logic [31:0] lo_nxt;
    logic [31:0] result;

    assign accept = (state == S_IDLE) && start && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_RUN;
            S_RUN: begin
                if (abort)              state_nxt = S_IDLE;
                else if (cnt == 5'd31)  state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != S_IDLE);
        done  = (state == S_DONE) && !abort;
        wb_en = done && (dst_q != 4'd0);
        div0  = done && div0_q;
    end

    assign wb_sel = dst_q;

    // One shift-add or restoring-division step.
    always_comb begin
        mul_sum  = hi_q + {1'b0, (lo_q[0] ? opd_q : 32'd0)};
        div_sh   = {hi_q[31:0], lo_q[31]};
        div_diff = {1'b0, div_sh} - {2'b00, opd_q};
        if (op_q[1]) begin
            hi_nxt = div_diff[33] ? div_sh : div_diff[32:0];
            lo_nxt = {lo_q[30:0], ~div_diff[33]};
        end else begin
            hi_nxt = {1'b0, mul_sum[32:1]};
            lo_nxt = {mul_sum[0], lo_q[31:1]};
        end
        // MUL/DIVU take the low word, MULHU/REMU the high word. A zero divisor
        // never borrows, so the quotient saturates to all-ones and the dividend
        // shifts through unchanged into the remainder.
        result = op_q[0] ? hi_nxt[31:0] : lo_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 5'd0;
            op_q    <= 2'd0;
            dst_q   <= 4'd0;
            div0_q  <= 1'b0;
            opd_q   <= 32'd0;
            hi_q    <= 33'd0;
            lo_q    <= 32'd0;
            wb_data <= 32'd0;
        end else if (accept) begin
            cnt    <= 5'd0;
            op_q   <= op;
            dst_q  <= dst;
            div0_q <= op[1] && (src_b == 32'd0);
            hi_q   <= 33'd0;
            lo_q   <= op[1] ? src_a : src_b;
            opd_q  <= op[1] ? src_b : src_a;
        end else if (state == S_RUN && !abort) begin
            cnt  <= cnt + 5'd1;
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
            if (cnt == 5'd31) wb_data <= result;
        end
    end

endmodule
